// File: rtl/inst_queue_pkg.sv
// Shared instruction/PC types and the queue entry record used by fetch, inst_queue and decode.
// Latency: none (types, constants and a helper function only).
// Backpressure: none; the NOP encoding is the canonical RISC-V "addi x0,x0,0".
`ifndef NOP
`define NOP 32'h0000_0013
`endif

package inst_queue_pkg;

  localparam int INST_W = 32;
  localparam int PC_W   = 32;

  typedef logic [INST_W-1:0] INST;
  typedef logic [PC_W-1:0]   PC;

  typedef struct packed {
    INST inst;
    PC   pc;
  } IQ_ENTRY;

  // Number of set bits in a 2-bit slot mask (0, 1 or 2).
  function automatic logic [1:0] popcount2(input logic [1:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]};
  endfunction

endpackage

// File: rtl/inst_queue_ptr_ctrl.sv
// Head/tail/count bookkeeping for inst_queue; computes enqueue and dequeue widths each cycle.
// Latency: pointers and count update on the clock edge after enqueue/dequeue/flush.
// Backpressure: in_ready from registered count only (>= 2 free); accept bits outside out_valid are ignored.
module iq_ptr_ctrl
  import inst_queue_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic [1:0]    in_valid,
  input  logic [1:0]    out_accept,
  output logic          in_ready,
  output logic [1:0]    out_valid,
  output logic [1:0]    enq_n,
  output logic [1:0]    deq_n,
  output logic [AW-1:0] head,
  output logic [AW-1:0] tail,
  output logic [CW-1:0] count
);

  logic acc0;
  logic acc1;

  assign in_ready  = (count <= CW'(DEPTH - 2));
  assign out_valid = {count >= CW'(2), count != '0};

  // A lone in_valid[1] is illegal and therefore enqueues nothing.
  assign enq_n = (in_ready && in_valid[0]) ? popcount2(in_valid) : 2'd0;

  // Only a valid prefix of the head slots can be consumed.
  assign acc0  = out_accept[0] & out_valid[0];
  assign acc1  = acc0 & out_accept[1] & out_valid[1];
  assign deq_n = popcount2({acc1, acc0});

  // Pointer/count update; flush overrides any same-cycle enqueue or dequeue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + AW'(deq_n);
      tail  <= tail + AW'(enq_n);
      count <= count + CW'(enq_n) - CW'(deq_n);
    end
  end

endmodule

// File: rtl/inst_queue.sv
// Two-wide FWFT instruction queue between 2-way fetch and decode; optional IQ_NOP_FILL_EN masks invalid slots.
// Latency: an entry written at edge N shows on out_* in cycle N+1 (no bypass); flush empties at the next edge.
// Backpressure: in_ready = at least two free entries, from registered count; fetch holds data while low.
module inst_queue
  import inst_queue_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic [1:0]               in_valid,
  input  logic [1:0][INST_W-1:0]   in_inst,
  input  logic [1:0][PC_W-1:0]     in_pc,
  output logic                     in_ready,
  output logic [1:0]               out_valid,
  output logic [1:0][INST_W-1:0]   out_inst,
  output logic [1:0][PC_W-1:0]     out_pc,
  input  logic [1:0]               out_accept,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [1:0]    enq_n;
  logic [1:0]    deq_n;
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [AW-1:0] tail_p1;
  logic [AW-1:0] head_p1;
  IQ_ENTRY       mem [DEPTH];
  IQ_ENTRY       rd0;
  IQ_ENTRY       rd1;

  iq_ptr_ctrl #(.DEPTH(DEPTH)) u_ptr (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .out_accept (out_accept),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .enq_n      (enq_n),
    .deq_n      (deq_n),
    .head       (head),
    .tail       (tail),
    .count      (count)
  );

  // Pointer arithmetic wraps naturally at DEPTH (power of two).
  assign tail_p1 = tail + AW'(1);
  assign head_p1 = head + AW'(1);

  // Storage write: slot 0 at tail, slot 1 at tail+1; storage itself is never reset.
  always_ff @(posedge clk) begin
    if (!flush && enq_n != 2'd0) begin
      mem[tail] <= '{inst: in_inst[0], pc: in_pc[0]};
    end
    if (!flush && enq_n == 2'd2) begin
      mem[tail_p1] <= '{inst: in_inst[1], pc: in_pc[1]};
    end
  end

  assign rd0 = mem[head];
  assign rd1 = mem[head_p1];

  // Head presentation, optionally masking slots that carry no valid entry.
  always_comb begin
`ifdef IQ_NOP_FILL_EN
    out_inst[0] = out_valid[0] ? rd0.inst : INST'(`NOP);
    out_pc[0]   = out_valid[0] ? rd0.pc   : '0;
    out_inst[1] = out_valid[1] ? rd1.inst : INST'(`NOP);
    out_pc[1]   = out_valid[1] ? rd1.pc   : '0;
`else
    out_inst[0] = rd0.inst;
    out_pc[0]   = rd0.pc;
    out_inst[1] = rd1.inst;
    out_pc[1]   = rd1.pc;
`endif
  end

  // deq_n is consumed by the pointer block; kept visible here for debug probes.
  logic unused_deq;
  assign unused_deq = ^deq_n;

endmodule

// File: tb/tb_inst_queue.sv
// Directed bench for inst_queue: stimulus pushes expected entries to a scoreboard, a monitor pops on accept.
// Latency: checks occupancy one cycle after each stimulus step.
// Backpressure: the bench's own occupancy tracker decides whether an enqueue is taken.
module tb_inst_queue;

  localparam int DEPTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic [1:0]       in_valid;
  logic [1:0][31:0] in_inst;
  logic [1:0][31:0] in_pc;
  logic             in_ready;
  logic [1:0]       out_valid;
  logic [1:0][31:0] out_inst;
  logic [1:0][31:0] out_pc;
  logic [1:0]       out_accept;
  logic [3:0]       count;

  int          n_chk  = 0;
  int          n_fail = 0;
  int          m_count = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  inst_queue #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_inst    (in_inst),
    .in_pc      (in_pc),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_inst   (out_inst),
    .out_pc     (out_pc),
    .out_accept (out_accept),
    .count      (count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk_inst(input logic [31:0] pc);
    return {16'hC0DE, pc[15:0]};
  endfunction

  // One clock of stimulus; expected entries are queued when the tracker says fetch is accepted.
  task automatic step(input logic [1:0] v, input logic [31:0] p0, input logic [31:0] p1,
                      input logic [1:0] acc, input logic fl);
    int enq;
    int deq;
    bit rdy;
    in_valid   = v;
    in_pc[0]   = p0;
    in_pc[1]   = p1;
    in_inst[0] = mk_inst(p0);
    in_inst[1] = mk_inst(p1);
    out_accept = acc;
    flush      = fl;
    rdy = (DEPTH - m_count) >= 2;
    if (fl) begin
      exp_q.delete();
      m_count = 0;
    end else begin
      enq = (rdy && v[0]) ? (v[1] ? 2 : 1) : 0;
      deq = (acc[0] ? 1 : 0) + ((acc[0] && acc[1]) ? 1 : 0);
      if (enq >= 1) exp_q.push_back({mk_inst(p0), p0});
      if (enq == 2) exp_q.push_back({mk_inst(p1), p1});
      m_count = m_count + enq - deq;
    end
    @(posedge clk);
    #1;
    in_valid   = 2'b00;
    out_accept = 2'b00;
    flush      = 1'b0;
    chk("count", 32'(count), 32'(m_count));
    chk("in_ready", 32'(in_ready), ((DEPTH - m_count) >= 2) ? 32'd1 : 32'd0);
    chk("out_valid", 32'(out_valid), {30'd0, m_count >= 2, m_count >= 1});
  endtask

  // Monitor: every accepted slot must match the oldest expected entry.
  always @(negedge clk) begin : mon
    logic [63:0] e;
    if (!rst && !flush) begin
      for (int i = 0; i < 2; i++) begin
        if (out_accept[i]) begin
          chk($sformatf("out_valid_slot%0d", i), 32'(out_valid[i]), 32'd1);
          if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL sb_underflow: slot %0d accepted, got pc %0h, required nothing pending", i, out_pc[i]);
          end else begin
            e = exp_q.pop_front();
            chk($sformatf("out_pc_slot%0d", i), out_pc[i], e[31:0]);
            chk($sformatf("out_inst_slot%0d", i), out_inst[i], e[63:32]);
          end
        end
      end
    end
  end

  initial begin
    rst        = 1'b1;
    flush      = 1'b0;
    in_valid   = 2'b00;
    in_inst    = '0;
    in_pc      = '0;
    out_accept = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    rst = 1'b0;

    // First double enqueue visible next cycle.
    step(2'b11, 32'h100, 32'h104, 2'b00, 1'b0);
    chk("first_count", 32'(count), 32'd2);
    chk("first_out_valid", 32'(out_valid), 32'd3);
    chk("first_pc0", out_pc[0], 32'h100);
    chk("first_pc1", out_pc[1], 32'h104);
    step(2'b00, 0, 0, 2'b11, 1'b0);

    // Fill to full, then a refused enqueue.
    for (int k = 0; k < 4; k++)
      step(2'b11, 32'h110 + 32'(8 * k), 32'h114 + 32'(8 * k), 2'b00, 1'b0);
    chk("full_count", 32'(count), 32'd8);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    step(2'b01, 32'h200, 0, 2'b00, 1'b0);
    chk("full_ignored_count", 32'(count), 32'd8);

    // Single dequeues: 8 -> 7 (still not ready) -> 6 (ready).
    step(2'b00, 0, 0, 2'b01, 1'b0);
    chk("c7_in_ready", 32'(in_ready), 32'd0);
    step(2'b00, 0, 0, 2'b01, 1'b0);
    chk("c6_count", 32'(count), 32'd6);
    chk("c6_in_ready", 32'(in_ready), 32'd1);
    repeat (3) step(2'b00, 0, 0, 2'b11, 1'b0);

    // Walk head/tail to index 7, then a double enqueue that splits across 7 -> 0.
    step(2'b11, 32'h120, 32'h124, 2'b00, 1'b0);
    step(2'b11, 32'h128, 32'h12c, 2'b00, 1'b0);
    step(2'b01, 32'h130, 0, 2'b00, 1'b0);
    step(2'b00, 0, 0, 2'b11, 1'b0);
    step(2'b00, 0, 0, 2'b11, 1'b0);
    step(2'b00, 0, 0, 2'b01, 1'b0);
    step(2'b11, 32'h300, 32'h304, 2'b00, 1'b0);
    chk("wrap_pc0", out_pc[0], 32'h300);
    chk("wrap_pc1", out_pc[1], 32'h304);
    step(2'b00, 0, 0, 2'b11, 1'b0);

    // Enqueue 2 while dequeuing 1 at count 3.
    step(2'b11, 32'h400, 32'h404, 2'b00, 1'b0);
    step(2'b01, 32'h408, 0, 2'b00, 1'b0);
    step(2'b11, 32'h40c, 32'h410, 2'b01, 1'b0);
    chk("mix_count", 32'(count), 32'd4);
    chk("mix_pc0", out_pc[0], 32'h404);

    // Flush at count 5 with concurrent enqueue and accept.
    step(2'b01, 32'h414, 0, 2'b00, 1'b0);
    step(2'b11, 32'h500, 32'h504, 2'b11, 1'b1);
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_in_ready", 32'(in_ready), 32'd1);
`ifdef IQ_NOP_FILL_EN
    chk("flush_nop0", out_inst[0], `NOP);
    chk("flush_nop1", out_inst[1], `NOP);
    chk("flush_pc0_zero", out_pc[0], 32'd0);
`endif
    step(2'b01, 32'h600, 0, 2'b00, 1'b0);
    chk("post_flush_pc0", out_pc[0], 32'h600);
    step(2'b00, 0, 0, 2'b01, 1'b0);

    // Asynchronous reset in mid-cycle drops everything immediately.
    step(2'b11, 32'h700, 32'h704, 2'b00, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    exp_q.delete();
    m_count = 0;
    rst = 1'b0;
    step(2'b11, 32'h710, 32'h714, 2'b00, 1'b0);
    chk("arst_after_pc0", out_pc[0], 32'h710);
    step(2'b00, 0, 0, 2'b11, 1'b0);

    chk("sb_leftover", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
